// File: rtl/iserdes_lite.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// iserdes_lite
//
// Single-clock 1:N serial-to-parallel deserializer. One serial bit is taken
// per clock-enabled edge. Each group of DATA_WIDTH accepted bits is presented
// on Q together with a one-cycle Q_VALID strobe. BITSLIP moves the word
// boundary one bit later for link alignment.
//
// Parameters
//   DATA_WIDTH : word width, 2..16
//   BIT_ORDER  : 0 = first received bit lands in Q[DATA_WIDTH-1]
//                1 = first received bit lands in Q[0]
//   INIT_Q     : value loaded into Q by reset
//
// Ports
//   CLK     in   clock, all state changes on the rising edge
//   RST     in   synchronous active-high reset, overrides everything else
//   CE      in   clock enable, a bit (and BITSLIP) is taken only when high
//   D       in   serial data bit
//   BITSLIP in   boundary slip request
//   Q       out  last completed word (holds between completions)
//   Q_VALID out  one-cycle strobe in the cycle after a word completes
//
// Output protocol: Q_VALID is a strobe with no back-pressure. A word is
// available on Q in exactly the cycle where Q_VALID=1 and stays on Q until
// the next completion or reset; the consumer cannot stall the stream.
// Both outputs come straight from flops.
// ---------------------------------------------------------------------------
module iserdes_lite #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    BIT_ORDER  = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_Q     = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic                  D,
    input  logic                  BITSLIP,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Q_VALID
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // History of the previous DATA_WIDTH-1 accepted bits, newest in bit 0.
    logic [DATA_WIDTH-2:0] sr;
    // Position of the next accepted bit within the current word.
    logic [CNT_W-1:0]      cnt;

    // The word as it would be if the current edge completed it: oldest bit
    // in the MSB, the bit being accepted right now in the LSB.
    logic [DATA_WIDTH-1:0] word_msb;
    logic [DATA_WIDTH-1:0] word_ordered;
    logic                  complete;

    assign word_msb = {sr, D};

    generate
        if (BIT_ORDER == 0) begin : g_msb_first
            assign word_ordered = word_msb;
        end else begin : g_lsb_first
            // First received bit goes to Q[0]: plain bit reversal.
            always_comb begin
                word_ordered = '0;
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    word_ordered[i] = word_msb[DATA_WIDTH-1-i];
                end
            end
        end
    endgenerate

    // A slip on the last bit of a word defers completion; the word then
    // completes on the next non-slip enabled edge using the newest bits.
    assign complete = CE && !BITSLIP && (cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr      <= '0;
            cnt     <= '0;
            Q       <= INIT_Q;
            Q_VALID <= 1'b0;
        end else begin
            Q_VALID <= complete;
            if (CE) begin
                // Data is shifted in on every enabled edge, slip or not;
                // a slip only freezes the bit counter.
                sr <= word_msb[DATA_WIDTH-2:0];
                if (!BITSLIP) begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
            end
            if (complete) begin
                Q <= word_ordered;
            end
        end
    end

endmodule

// File: tb/tb_iserdes_lite.sv
`timescale 1ns/1ps
module tb_iserdes_lite;

  localparam int         W      = 8;
  localparam logic [7:0] INIT_V = 8'h5A;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE = 1'b0;
  logic       D = 1'b0;
  logic       BITSLIP = 1'b0;
  logic [7:0] q_msb, q_lsb;
  logic       v_msb, v_lsb;

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  iserdes_lite #(.DATA_WIDTH(W), .BIT_ORDER(0), .INIT_Q(INIT_V)) u_msb (
    .CLK(CLK), .RST(RST), .CE(CE), .D(D), .BITSLIP(BITSLIP),
    .Q(q_msb), .Q_VALID(v_msb)
  );

  iserdes_lite #(.DATA_WIDTH(W), .BIT_ORDER(1), .INIT_Q(INIT_V)) u_lsb (
    .CLK(CLK), .RST(RST), .CE(CE), .D(D), .BITSLIP(BITSLIP),
    .Q(q_lsb), .Q_VALID(v_lsb)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_lsb_q[$];
  int           exp_cyc_q[$];

  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", tag, act, exp, edge_cnt);
  endtask

  function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Reference model: bit history plus position within the word.
  logic [15:0] hist = '0;
  int          mcnt = 0;
  int          rst_edge = -1;

  // ---------------- driver tasks ----------------
  // Inputs are set 1 time unit after a rising edge and take effect on the
  // following edge, numbered edge_cnt+1.
  task automatic drive(input logic ce, input logic d, input logic bs);
    logic [W-1:0] w;
    @(posedge CLK);
    #1;
    RST = 1'b0; CE = ce; D = d; BITSLIP = bs;
    if (ce) begin
      hist = {hist[14:0], d};
      if (!bs) begin
        if (mcnt == W - 1) begin
          w = hist[W-1:0];
          exp_q.push_back(w);
          exp_lsb_q.push_back(bit_rev(w));
          exp_cyc_q.push_back(edge_cnt + 1);
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      #1;
      RST = 1'b1; CE = 1'b1; D = 1'($urandom_range(0, 1)); BITSLIP = 1'($urandom_range(0, 1));
      rst_edge = edge_cnt + 1;
    end
    hist = '0;
    mcnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) drive(1'b1, b[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // ---------------- monitor ----------------
  logic         mon_en = 1'b0;
  logic [W-1:0] hold_m = INIT_V;
  logic [W-1:0] hold_l = INIT_V;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (edge_cnt == rst_edge) begin
        hold_m = INIT_V;
        hold_l = INIT_V;
      end
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == edge_cnt) begin
        void'(exp_cyc_q.pop_front());
        hold_m = exp_q.pop_front();
        hold_l = exp_lsb_q.pop_front();
        check("valid_msb", 16'(v_msb), 16'd1);
        check("valid_lsb", 16'(v_lsb), 16'd1);
        check("q_msb", 16'(q_msb), 16'(hold_m));
        check("q_lsb", 16'(q_lsb), 16'(hold_l));
      end else begin
        check("no_valid_msb", 16'(v_msb), 16'd0);
        check("no_valid_lsb", 16'(v_lsb), 16'd0);
        check("q_hold_msb", 16'(q_msb), 16'(hold_m));
        check("q_hold_lsb", 16'(q_lsb), 16'(hold_l));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, check_cnt);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] slip_stream;
    logic [7:0]  b;
    int          k;

    // Reset and idle with CE low.
    do_reset(2);
    drive(1'b0, 1'b0, 1'b0);
    check("reset_q_msb", 16'(q_msb), 16'h005A);
    check("reset_q_lsb", 16'(q_lsb), 16'h005A);
    check("reset_valid", 16'(v_msb), 16'd0);
    mon_en = 1'b1;
    idle(20);

    // Continuous MSB-first stream A5, 3C.
    do_reset(1);
    send_byte(8'hA5);
    send_byte(8'h3C);
    idle(1);
    check("stream_last_msb", 16'(q_msb), 16'h003C);

    // LSB-first: sequence 1,0,1,0,0,1,0,1.
    do_reset(1);
    b = 8'b1010_0101;
    for (int i = 7; i >= 0; i--) drive(1'b1, b[i], 1'b0);
    idle(1);
    check("lsb_first_a5", 16'(q_lsb), 16'h00A5);

    // Bitslip on edge 1, then again when the second word sits on its last bit.
    do_reset(1);
    slip_stream = 24'hA53CF0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, slip_stream[23-i], (i == 0 || i == 16) ? 1'b1 : 1'b0);
      if (i == 9) check("slip_first_word", 16'(q_msb), 16'h004A);
    end
    idle(2);

    // CE gaps inside a word.
    do_reset(1);
    b = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, b[i], 1'b0);
      if (i == 6 || i == 3) idle(3);
    end
    idle(1);
    check("ce_gap_word", 16'(q_msb), 16'h00C3);

    // Reset mid-word discards partial bits.
    do_reset(1);
    send_byte(8'hFF);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    do_reset(1);
    send_byte(8'h96);
    idle(1);
    check("mid_reset_word", 16'(q_msb), 16'h0096);

    // Random traffic with occasional slips and CE gaps.
    k = 0;
    while (k < 200) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0));
      k++;
    end
    // Consecutive slips.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    idle(3);

    check("drain", 16'(exp_q.size()), 16'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
